// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit with its issue/stall sequencer for the EX stage.
// Define MULDIV_EARLY_OUT_EN to finish divides whose |a| < |b| straight from IDLE.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              valid_q, valid_d;

    logic              div_signed_in;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              b_zero, div_ovf;

    assign div_signed_in = ~funct3[0];
    assign abs_a  = (div_signed_in & operand_a[XLEN-1]) ? -operand_a : operand_a;
    assign abs_b  = (div_signed_in & operand_b[XLEN-1]) ? -operand_b : operand_b;
    assign b_zero = (operand_b == '0);
    assign div_ovf = div_signed_in & (operand_a == MIN_NEG) & (operand_b == '1);

    // Low 2*XLEN bits of a sign-extended product are exact for every signedness mix.
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [XLEN-1:0]   mul_word;

    assign a_sgn    = (funct3_q[1:0] == 2'b01) | (funct3_q[1:0] == 2'b10);
    assign b_sgn    = (funct3_q[1:0] == 2'b01);
    assign mul_a    = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign mul_b    = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign product  = mul_a * mul_b;
    assign mul_word = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    // Restoring step: a_q shifts the dividend out and the quotient in.
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              rem_ge;
    logic [XLEN-1:0]   q_fix, r_fix, div_word;

    assign rem_shift = {rem_q, a_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign rem_ge    = ~rem_diff[XLEN];
    assign q_fix     = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
    assign r_fix     = sign_a_q ? -rem_q : rem_q;
    assign div_word  = funct3_q[1] ? r_fix : q_fix;

    assign stall = ((state_q == S_IDLE) & start & ~flush)
                 | (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
    assign result_valid = valid_q;
    assign result       = result_q;

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        result_d = result_q;
        count_d  = count_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start & ~flush) begin
                    funct3_d = funct3;
                    if (!funct3[2]) begin
                        a_d     = operand_a;
                        b_d     = operand_b;
                        state_d = S_MUL;
                    end else if (b_zero) begin
                        result_d = funct3[1] ? operand_a : '1;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : MIN_NEG;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (abs_a < abs_b) begin
                        result_d = funct3[1] ? operand_a : '0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`endif
                    end else begin
                        a_d      = abs_a;
                        b_d      = abs_b;
                        sign_a_d = div_signed_in & operand_a[XLEN-1];
                        sign_b_d = div_signed_in & operand_b[XLEN-1];
                        rem_d    = '0;
                        count_d  = CNT_W'(XLEN-1);
                        state_d  = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = mul_word;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d     = {a_q[XLEN-2:0], rem_ge};
                    rem_d   = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    count_d = count_q - CNT_W'(1);
                    if (count_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = div_word;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            count_q  <= count_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus random ops
// against an arithmetic reference; honours MULDIV_EARLY_OUT_EN for expected latency.
module tb_muldiv_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    int vectors;
    int miscompares;
    logic [31:0] lastResult;

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .start        (start),
        .funct3       (funct3),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: plain 64-bit arithmetic with RISC-V divide special cases.
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        p = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? -a : a;
        mb = (!f3[0] && b[31]) ? -b : b;
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        if (ma == mb) return 34;
        return 34;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one op at a negedge (cycle 0) and checks stall/valid/result per cycle.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] exp;
        string tag;
        lat = refLatency(f3, a, b);
        exp = refResult(f3, a, b);
        tag = $sformatf("op f3=%0d a=%h b=%h", f3, a, b);
        @(negedge CLK);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        #1;
        checkOutput({tag, " stall c0"}, {31'b0, stall}, 32'd1);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge CLK);
            start = 1'b0;
            #1;
            checkOutput($sformatf("%s stall c%0d", tag, c), {31'b0, stall}, {31'b0, c < lat});
            checkOutput($sformatf("%s valid c%0d", tag, c), {31'b0, result_valid},
                        {31'b0, c == lat});
            if (c == lat)     checkOutput({tag, " result"}, result, exp);
            if (c == lat + 1) checkOutput({tag, " result hold"}, result, exp);
        end
        lastResult = exp;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        lastResult  = '0;
        RESET_N     = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        funct3      = '0;
        operand_a   = '0;
        operand_b   = '0;

        #12;
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset valid", {31'b0, result_valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        applyStimulus(3'd0, 32'd7, 32'd6);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(3'd4, -32'sd7, 32'd2);
        applyStimulus(3'd6, -32'sd7, 32'd2);
        applyStimulus(3'd5, 32'd100, 32'd7);
        applyStimulus(3'd7, 32'd100, 32'd7);
        applyStimulus(3'd5, 32'd5, 32'd0);
        applyStimulus(3'd7, 32'd5, 32'd0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(3'd5, 32'd3, 32'd10);
        applyStimulus(3'd7, 32'd3, 32'd10);
        applyStimulus(3'd6, -32'sd3, 32'd10);
        applyStimulus(3'd4, 32'h8000_0000, 32'd1);

        // Flush in cycle 10 of a divide.
        @(negedge CLK);
        start = 1'b1; funct3 = 3'd5; operand_a = 32'd1000; operand_b = 32'd3;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            start = 1'b0;
            flush = (c == 10);
            #1;
            if (c == 11) checkOutput("flush stall c11", {31'b0, stall}, 32'd0);
            if (c >= 11) checkOutput($sformatf("flush valid c%0d", c), {31'b0, result_valid}, 32'd0);
            if (c == 11 || c == 40) checkOutput("flush result held", result, lastResult);
        end

        // start together with flush in IDLE is not accepted.
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9;
        #1;
        checkOutput("start+flush stall", {31'b0, stall}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            start = 1'b0; flush = 1'b0;
            #1;
            checkOutput($sformatf("start+flush stall c%0d", c), {31'b0, stall}, 32'd0);
            checkOutput($sformatf("start+flush valid c%0d", c), {31'b0, result_valid}, 32'd0);
        end

        // Reset asserted in cycle 5 of a divide.
        @(negedge CLK);
        start = 1'b1; funct3 = 3'd4; operand_a = 32'd12345; operand_b = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        RESET_N = 1'b0;
        #1;
        checkOutput("midreset stall", {31'b0, stall}, 32'd0);
        checkOutput("midreset valid", {31'b0, result_valid}, 32'd0);
        checkOutput("midreset result", result, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        lastResult = '0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 15));
                1: a = 32'($urandom_range(0, 15));
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyStimulus(f3, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
